barrel_shift_right_pipe: RTL and testbench



---
 rtl/barrel_shift_right_pipe.sv | 66 ++++++
 tb/tb_barrel_shift_right_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/barrel_shift_right_pipe.sv
// barrel_shift_right_pipe: pipelined right barrel shifter, one stage per shift-amount bit, valid/ready with global stall.
module barrel_shift_right_pipe #(
    parameter int WIDTH  = 64,
    parameter int SAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  D_in,
    input  logic [SAMT_W-1:0] samt,
    input  logic [1:0]        fill,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  D_out,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int N = SAMT_W;
    logic [WIDTH-1:0]  src_dat [N];
    logic [SAMT_W-1:0] src_amt [N];
    logic [1:0]        src_fil [N];
    logic              src_sgn [N];
    logic [WIDTH-1:0]  dat_d   [N];
    logic [WIDTH-1:0]  dat_q   [N];
    logic [SAMT_W-1:0] amt_q   [N-1];
    logic [1:0]        fil_q   [N-1];
    logic              sgn_q   [N-1];
    logic [N-1:0]      vld_q;
    logic              adv;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign D_out     = dat_q[N-1];
    assign out_valid = vld_q[N-1];
    assign src_dat[0] = D_in;
    assign src_amt[0] = samt;
    assign src_fil[0] = fill;
    assign src_sgn[0] = D_in[WIDTH-1];
    genvar k;
    for (k = 0; k < N; k++) begin : g_st
        localparam int SH = 1 << (N - 1 - k);
        logic [WIDTH-1:0] fv;
        // Remaining shift bits travel MSB-first, so each stage tests the top bit.
        assign fv = src_fil[k] == 2'b11 ? src_dat[k]
                  : {WIDTH{src_fil[k] == 2'b00 | (src_fil[k] == 2'b10 & src_sgn[k])}};
        assign dat_d[k] = src_amt[k][N-1] ? (src_dat[k] >> SH) | (fv << (WIDTH - SH)) : src_dat[k];
        if (k < N - 1) begin : g_nx
            assign src_dat[k+1] = dat_q[k];
            assign src_amt[k+1] = amt_q[k];
            assign src_fil[k+1] = fil_q[k];
            assign src_sgn[k+1] = sgn_q[k];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            dat_q[N-1] <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[N-2:0], in_valid};
            for (int i = 0; i < N; i++) dat_q[i] <= dat_d[i];
            for (int i = 0; i < N - 1; i++) begin
                amt_q[i] <= src_amt[i] << 1;
                fil_q[i] <= src_fil[i];
                sgn_q[i] <= src_sgn[i];
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// tb_barrel_shift_right_pipe: directed and random checks of the right shifter against a queue-based reference.
module tb_barrel_shift_right_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] D_in = '0;
    logic [4:0]  samt = '0;
    logic [1:0]  fill = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] D_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [63:0] q [$];
    logic        hold_v = 1'b0;
    logic [63:0] hold_d = '0;

    barrel_shift_right_pipe dut (
        .clk(clk), .rst(rst), .D_in(D_in), .samt(samt), .fill(fill),
        .in_valid(in_valid), .in_ready(in_ready), .D_out(D_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input logic [1:0] f);
        case (f)
            2'b00:   return (d >> s) | ~(64'hFFFF_FFFF_FFFF_FFFF >> s);
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (d >> s) | (d << (64 - s));
        endcase
    endfunction

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Scoreboard: transfers are evaluated where the next rising edge will sample them.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (hold_v) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_data", D_out, hold_d);
            end
            check("in_ready", {63'b0, in_ready}, {63'b0, out_ready | ~out_valid});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h expected none", D_out);
                end else begin
                    check("stream_data", D_out, q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(ref_shift(D_in, int'(samt), fill));
        end
        hold_v = out_valid & ~out_ready & ~rst;
        hold_d = D_out;
    end

    task automatic send_one(input string n, input logic [63:0] d, input logic [4:0] s,
                            input logic [1:0] f, input logic [63:0] e);
        D_in = d; samt = s; fill = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check({n, "_early"}, {63'b0, out_valid}, 64'd0);
        @(posedge clk);
        #1 check({n, "_valid"}, {63'b0, out_valid}, 64'd1);
        check(n, D_out, e);
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt, first, last;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_D_out", D_out, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);

        send_one("zero7", 64'h80, 5'd7, 2'b01, 64'h1);
        send_one("ones4", 64'h0, 5'd4, 2'b00, 64'hF000_0000_0000_0000);
        send_one("sign31", 64'h8000_0000_0000_0000, 5'd31, 2'b10, 64'hFFFF_FFFF_0000_0000);
        send_one("zero31", 64'h8000_0000_0000_0000, 5'd31, 2'b01, 64'h0000_0001_0000_0000);
        send_one("rot1", 64'h1, 5'd1, 2'b11, 64'h8000_0000_0000_0000);
        for (int f = 0; f < 4; f++)
            send_one("ident", 64'h0123_4567_89AB_CDEF, 5'd0, 2'(f), 64'h0123_4567_89AB_CDEF);
        send_one("rot8", 64'h0123_4567_89AB_CDEF, 5'd8, 2'b11, 64'hEF01_2345_6789_ABCD);

        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 45; i++) begin
            in_valid = i < 32;
            D_in = {$urandom, $urandom}; samt = 5'(i); fill = 2'($urandom);
            @(posedge clk); #1;
            if (out_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        in_valid = 1'b0;
        check("stream_count", 64'(cnt), 64'd32);
        check("stream_first", 64'(first), 64'd4);
        check("stream_last", 64'(last), 64'd35);

        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            D_in = {$urandom, $urandom}; samt = 5'($urandom); fill = 2'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("drain_empty", 64'(q.size()), 64'd0);

        for (int i = 0; i < 4; i++) begin
            D_in = {$urandom, $urandom}; samt = 5'($urandom); fill = 2'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_data", D_out, 64'd0);
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("midrst_ghosts", 64'(cnt), 64'd0);
        send_one("post_rst", 64'hFFFF_0000_0000_0000, 5'd16, 2'b01, 64'h0000_FFFF_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
